mem_access_stage: RTL and testbench

- Memory stage directly downstream of the EX-stage ALU.
- Takes the ALU result as an effective address, or as a pass-through value, and performs byte, half and word loads and stores against the data memory over a req/ack handshake.
- Formats load data (sign- or zero-extended) and flags misaligned accesses.
- Presents one result per accepted op to writeback.
- Multi-cycle; back-pressures EX via in_ready.

---
 rtl/mem_access_stage_pkg.sv | 44 ++++
 rtl/mem_access_stage_if.sv | 23 ++
 rtl/mem_access_stage_load_align.sv | 29 ++
 rtl/mem_access_stage.sv | 154 +++++++++++++++
 tb/tb_mem_access_stage.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory stage: op codes, FSM states, op decode helpers.
package mem_access_stage_pkg;

    localparam int MEM_OP_W   = 4;
    localparam int MEM_DATA_W = 32;

    typedef enum logic [MEM_OP_W-1:0] {
        MEM_OP_NONE = 4'd0,
        MEM_OP_LB   = 4'd1,
        MEM_OP_LBU  = 4'd2,
        MEM_OP_LH   = 4'd3,
        MEM_OP_LHU  = 4'd4,
        MEM_OP_LW   = 4'd5,
        MEM_OP_SB   = 4'd6,
        MEM_OP_SH   = 4'd7,
        MEM_OP_SW   = 4'd8
    } mem_op_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // Access size in bytes; 0 means the op does not touch memory (incl. codes 9-15).
    function automatic logic [2:0] op_size(input logic [MEM_OP_W-1:0] op);
        case (op)
            MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: op_size = 3'd1;
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: op_size = 3'd2;
            MEM_OP_LW, MEM_OP_SW:             op_size = 3'd4;
            default:                          op_size = 3'd0;
        endcase
    endfunction

    function automatic logic is_store(input logic [MEM_OP_W-1:0] op);
        return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
    endfunction

    function automatic logic is_misaligned(input logic [MEM_OP_W-1:0] op, input logic [1:0] off);
        logic [2:0] sz;
        sz = op_size(op);
        return ((sz == 3'd2) && off[0]) || ((sz == 3'd4) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage and the data memory.
interface mem_access_stage_if;
    import mem_access_stage_pkg::*;

    logic                  dmem_req;
    logic                  dmem_we;
    logic [MEM_DATA_W-1:0] dmem_addr;
    logic [3:0]            dmem_be;
    logic [MEM_DATA_W-1:0] dmem_wdata;
    logic                  dmem_ack;
    logic [MEM_DATA_W-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );

endinterface

// File: rtl/mem_access_stage_load_align.sv
// Picks the addressed byte/half out of a read word and extends it to 32 bits.
module mem_access_stage_load_align
    import mem_access_stage_pkg::*;
(
    input  logic [MEM_OP_W-1:0]   op,
    input  logic [1:0]            off,
    input  logic [MEM_DATA_W-1:0] rdata,
    output logic [MEM_DATA_W-1:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Lane select followed by sign/zero extension; non-load ops yield 0.
    always_comb begin
        byte_v = rdata[{off, 3'b000} +: 8];
        half_v = rdata[{off[1], 4'b0000} +: 16];
        data   = '0;
        case (op)
            MEM_OP_LB:  data = {{24{byte_v[7]}}, byte_v};
            MEM_OP_LBU: data = {24'd0, byte_v};
            MEM_OP_LH:  data = {{16{half_v[15]}}, half_v};
            MEM_OP_LHU: data = {16'd0, half_v};
            MEM_OP_LW:  data = rdata;
            default:    data = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: issues loads/stores on the dmem bus, formats results for writeback.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | ready for an op; NONE and misaligned ops complete from here
// WAIT    | request outstanding on dmem, held until dmem_ack
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MEM_OP_W-1:0] in_mem_op,
    input  logic [DATA_W-1:0]   in_alu_out,
    input  logic [DATA_W-1:0]   in_store_data,
    mem_access_stage_if.master  dmem,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_addr_err,
    output logic [DATA_W-1:0]   out_bad_addr
);

    state_e              state_q, state_d;
    logic [MEM_OP_W-1:0] op_q, op_d;
    logic [1:0]          off_q, off_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [3:0]          be_q, be_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_err_q, out_err_d;
    logic [DATA_W-1:0]   out_bad_q, out_bad_d;
    logic [DATA_W-1:0]   load_data;

    mem_access_stage_load_align u_load_align (
        .op    (op_q),
        .off   (off_q),
        .rdata (dmem.dmem_rdata),
        .data  (load_data)
    );

    assign in_ready        = (state_q == ST_IDLE);
    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_be    = be_q;
    assign dmem.dmem_wdata = wdata_q;
    assign out_valid       = out_valid_q;
    assign out_data        = out_data_q;
    assign out_addr_err    = out_err_q;
    assign out_bad_addr    = out_bad_q;

    // State and output registers; synchronous reset abandons any outstanding request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            off_q       <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            out_bad_q   <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            off_q       <= off_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            out_bad_q   <= out_bad_d;
        end
    end

    // Next-state and next-output decode; bus fields and result values hold unless updated.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        off_d       = off_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_err_d   = 1'b0;
        out_bad_d   = out_bad_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (op_size(in_mem_op) == 3'd0) begin
                        out_valid_d = 1'b1;
                        out_data_d  = in_alu_out;
                    end else if (is_misaligned(in_mem_op, in_alu_out[1:0])) begin
                        out_valid_d = 1'b1;
                        out_err_d   = 1'b1;
                        out_bad_d   = in_alu_out;
                        out_data_d  = '0;
                    end else begin
                        op_d    = in_mem_op;
                        off_d   = in_alu_out[1:0];
                        req_d   = 1'b1;
                        we_d    = is_store(in_mem_op);
                        addr_d  = {in_alu_out[DATA_W-1:2], 2'b00};
                        state_d = ST_WAIT;
                        case (in_mem_op)
                            MEM_OP_SB: begin
                                be_d    = 4'b0001 << in_alu_out[1:0];
                                wdata_d = {4{in_store_data[7:0]}};
                            end
                            MEM_OP_SH: begin
                                be_d    = in_alu_out[1] ? 4'b1100 : 4'b0011;
                                wdata_d = {2{in_store_data[15:0]}};
                            end
                            MEM_OP_SW: begin
                                be_d    = 4'b1111;
                                wdata_d = in_store_data;
                            end
                            default: begin
                                be_d    = 4'b1111;
                                wdata_d = '0;
                            end
                        endcase
                    end
                end
            end
            ST_WAIT: begin
                if (dmem.dmem_ack) begin
                    req_d       = 1'b0;
                    out_valid_d = 1'b1;
                    out_data_d  = we_q ? '0 : load_data;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed vector table, hand-written
// multi-cycle sequences, and randomized ops against an arithmetic reference model.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_mem_op;
    logic [31:0] in_alu_out;
    logic [31:0] in_store_data;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_addr_err;
    logic [31:0] out_bad_addr;

    mem_access_stage_if bus ();

    mem_access_stage #(.DATA_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_mem_op     (in_mem_op),
        .in_alu_out    (in_alu_out),
        .in_store_data (in_store_data),
        .dmem          (bus),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_addr_err  (out_addr_err),
        .out_bad_addr  (out_bad_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_mem;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] data;
        logic        err;
        logic [31:0] bad;
        int          latency;
    } exp_t;

    typedef struct {
        bit          seen;
        int          latency;
        bit          got_req;
        bit          req_stable;
        int          req_cycles;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] data;
        logic        err;
        logic [31:0] bad;
    } res_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] alu;
        logic [31:0] rt;
        logic [31:0] rdata;
        int          delay;
        exp_t        e;
    } vec_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    vec_t vecs[$];

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
    endtask

    function automatic exp_t exp_pass(input logic [31:0] v);
        exp_t e = '{default: '0};
        e.data = v; e.latency = 1;
        return e;
    endfunction

    function automatic exp_t exp_err(input logic [31:0] a);
        exp_t e = '{default: '0};
        e.err = 1'b1; e.bad = a; e.latency = 1;
        return e;
    endfunction

    function automatic exp_t exp_load(input logic [31:0] a, input logic [31:0] v, input int d);
        exp_t e = '{default: '0};
        e.is_mem = 1'b1; e.addr = a; e.be = 4'hF; e.data = v; e.latency = d + 2;
        return e;
    endfunction

    function automatic exp_t exp_store(input logic [31:0] a, input logic [3:0] be,
                                       input logic [31:0] wd, input int d);
        exp_t e = '{default: '0};
        e.is_mem = 1'b1; e.we = 1'b1; e.addr = a; e.be = be; e.wdata = wd; e.latency = d + 2;
        return e;
    endfunction

    // Reference model: sizes, offsets, masks and extension done with plain arithmetic.
    function automatic exp_t ref_model(input logic [3:0] op, input logic [31:0] alu,
                                       input logic [31:0] rt, input logic [31:0] rdata,
                                       input int delay);
        exp_t        e = '{default: '0};
        int          size;
        int          off;
        logic [63:0] mask;
        logic [63:0] v;
        logic [63:0] rep;
        off = int'(alu % 32'd4);
        case (int'(op))
            1, 2, 6: size = 1;
            3, 4, 7: size = 2;
            5, 8:    size = 4;
            default: size = 0;
        endcase
        e.latency = 1;
        if (size == 0) begin
            e.data = alu;
        end else if ((off % size) != 0) begin
            e.err = 1'b1;
            e.bad = alu;
        end else begin
            e.is_mem  = 1'b1;
            e.latency = delay + 2;
            e.addr    = alu - 32'(off);
            e.we      = (int'(op) >= 6);
            mask      = (64'd1 << (8 * size)) - 64'd1;
            if (e.we) begin
                e.be    = 4'(((1 << size) - 1) << off);
                rep     = (size == 1) ? 64'h01010101 : (size == 2) ? 64'h00010001 : 64'd1;
                v       = ({32'd0, rt} & mask) * rep;
                e.wdata = v[31:0];
            end else begin
                e.be = 4'hF;
                v    = ({32'd0, rdata} >> (8 * off)) & mask;
                if ((int'(op) == 1 || int'(op) == 3) && v >= ((mask + 64'd1) / 64'd2))
                    v = v + ~mask;
                e.data = v[31:0];
            end
        end
        return e;
    endfunction

    // Presents one op, plays the memory with the given ack delay, collects the result.
    task automatic do_op(input logic [3:0] op, input logic [31:0] alu, input logic [31:0] rt,
                         input logic [31:0] rdata, input int delay, output res_t r);
        int wait_cnt;
        int cyc;
        r = '{default: '0};
        r.req_stable = 1'b1;
        in_valid      = 1'b1;
        in_mem_op     = op;
        in_alu_out    = alu;
        in_store_data = rt;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_cnt = delay;
        cyc      = 1;
        while (cyc <= 40) begin
            if (out_valid) begin
                r.seen    = 1'b1;
                r.latency = cyc;
                r.data    = out_data;
                r.err     = out_addr_err;
                r.bad     = out_bad_addr;
                break;
            end
            if (bus.dmem_req) begin
                if (!r.got_req) begin
                    r.got_req = 1'b1;
                    r.we      = bus.dmem_we;
                    r.addr    = bus.dmem_addr;
                    r.be      = bus.dmem_be;
                    r.wdata   = bus.dmem_wdata;
                end else if (bus.dmem_we !== r.we || bus.dmem_addr !== r.addr ||
                             bus.dmem_be !== r.be || bus.dmem_wdata !== r.wdata) begin
                    r.req_stable = 1'b0;
                end
                r.req_cycles++;
                if (wait_cnt == 0) begin
                    bus.dmem_ack   = 1'b1;
                    bus.dmem_rdata = rdata;
                end else begin
                    wait_cnt--;
                    bus.dmem_rdata = $urandom;
                end
            end
            @(posedge clk); #1;
            bus.dmem_ack   = 1'b0;
            bus.dmem_rdata = $urandom;
            cyc++;
        end
    endtask

    task automatic compare(input string tag, input res_t r, input exp_t e, input int delay);
        check32({tag, " out_valid_seen"}, 32'(r.seen), 32'd1);
        check32({tag, " latency"}, 32'(r.latency), 32'(e.latency));
        check32({tag, " out_data"}, r.data, e.data);
        check32({tag, " out_addr_err"}, 32'(r.err), 32'(e.err));
        if (e.err) check32({tag, " out_bad_addr"}, r.bad, e.bad);
        check32({tag, " dmem_req_issued"}, 32'(r.got_req), 32'(e.is_mem));
        if (e.is_mem && r.got_req) begin
            check32({tag, " dmem_we"}, 32'(r.we), 32'(e.we));
            check32({tag, " dmem_addr"}, r.addr, e.addr);
            check32({tag, " dmem_be"}, 32'(r.be), 32'(e.be));
            check32({tag, " dmem_wdata"}, r.wdata, e.wdata);
            check32({tag, " req_stable"}, 32'(r.req_stable), 32'd1);
            check32({tag, " req_cycles"}, 32'(r.req_cycles), 32'(delay + 1));
        end
    endtask

    task automatic add_vec(input logic [3:0] op, input logic [31:0] alu, input logic [31:0] rt,
                           input logic [31:0] rdata, input int d, input exp_t e);
        vec_t v;
        v.op = op; v.alu = alu; v.rt = rt; v.rdata = rdata; v.delay = d; v.e = e;
        vecs.push_back(v);
    endtask

    initial begin
        res_t        r;
        exp_t        e;
        logic [31:0] held;
        rst            = 1'b1;
        in_valid       = 1'b0;
        in_mem_op      = '0;
        in_alu_out     = '0;
        in_store_data  = '0;
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = '0;

        add_vec(MEM_OP_LB,   32'h0000_1003, 32'h0,         32'h80FF_1234, 2, exp_load(32'h1000, 32'hFFFF_FF80, 2));
        add_vec(MEM_OP_LBU,  32'h0000_1003, 32'h0,         32'h80FF_1234, 2, exp_load(32'h1000, 32'h0000_0080, 2));
        add_vec(MEM_OP_LB,   32'h0000_1001, 32'h0,         32'h80FF_1234, 0, exp_load(32'h1000, 32'h0000_0012, 0));
        add_vec(MEM_OP_SH,   32'h0000_2002, 32'hDEAD_BEEF, 32'h0,         0, exp_store(32'h2000, 4'b1100, 32'hBEEF_BEEF, 0));
        add_vec(MEM_OP_SB,   32'h0000_0101, 32'h0000_00A5, 32'h0,         1, exp_store(32'h0100, 4'b0010, 32'hA5A5_A5A5, 1));
        add_vec(MEM_OP_SW,   32'h0000_0200, 32'h1122_3344, 32'h0,         3, exp_store(32'h0200, 4'b1111, 32'h1122_3344, 3));
        add_vec(MEM_OP_LW,   32'h0000_3001, 32'h0,         32'h0,         0, exp_err(32'h3001));
        add_vec(MEM_OP_LH,   32'h0000_3001, 32'h0,         32'h0,         0, exp_err(32'h3001));
        add_vec(MEM_OP_SH,   32'h0000_2001, 32'h0,         32'h0,         0, exp_err(32'h2001));
        add_vec(MEM_OP_NONE, 32'h1234_5678, 32'h0,         32'h0,         0, exp_pass(32'h1234_5678));
        add_vec(4'd12,       32'hABCD_0003, 32'h0,         32'h0,         0, exp_pass(32'hABCD_0003));
        add_vec(MEM_OP_LH,   32'h0000_0010, 32'h0,         32'h7FFF_8001, 1, exp_load(32'h0010, 32'hFFFF_8001, 1));
        add_vec(MEM_OP_LHU,  32'h0000_0012, 32'h0,         32'h7FFF_8001, 0, exp_load(32'h0010, 32'h0000_7FFF, 0));
        add_vec(MEM_OP_LW,   32'h0000_4000, 32'h0,         32'hCAFE_F00D, 1, exp_load(32'h4000, 32'hCAFE_F00D, 1));

        repeat (3) @(posedge clk);
        #1;
        check32("reset in_ready", 32'(in_ready), 32'd1);
        check32("reset dmem_req", 32'(bus.dmem_req), 32'd0);
        check32("reset dmem_we", 32'(bus.dmem_we), 32'd0);
        check32("reset dmem_addr", bus.dmem_addr, 32'd0);
        check32("reset dmem_be", 32'(bus.dmem_be), 32'd0);
        check32("reset dmem_wdata", bus.dmem_wdata, 32'd0);
        check32("reset out_valid", 32'(out_valid), 32'd0);
        check32("reset out_data", out_data, 32'd0);
        check32("reset out_addr_err", 32'(out_addr_err), 32'd0);
        check32("reset out_bad_addr", out_bad_addr, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table; each result is followed by a pulse/hold check one cycle later.
        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].alu, vecs[i].rt, vecs[i].rdata, vecs[i].delay, r);
            compare($sformatf("vec%0d", i), r, vecs[i].e, vecs[i].delay);
            held = out_data;
            @(posedge clk); #1;
            check32($sformatf("vec%0d pulse out_valid", i), 32'(out_valid), 32'd0);
            check32($sformatf("vec%0d pulse out_addr_err", i), 32'(out_addr_err), 32'd0);
            check32($sformatf("vec%0d hold out_data", i), out_data, vecs[i].e.data);
            check32($sformatf("vec%0d hold unchanged", i), out_data, held);
        end

        // NONE followed back-to-back by LW, accepted in the out_valid cycle.
        in_valid = 1'b1; in_mem_op = MEM_OP_NONE; in_alu_out = 32'h1234_5678; in_store_data = '0;
        @(posedge clk); #1;
        check32("b2b none out_valid", 32'(out_valid), 32'd1);
        check32("b2b none out_data", out_data, 32'h1234_5678);
        check32("b2b in_ready at out_valid", 32'(in_ready), 32'd1);
        in_mem_op = MEM_OP_LW; in_alu_out = 32'h0000_4000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check32("b2b lw in_ready in WAIT", 32'(in_ready), 32'd0);
        check32("b2b lw dmem_req", 32'(bus.dmem_req), 32'd1);
        check32("b2b lw dmem_addr", bus.dmem_addr, 32'h0000_4000);
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        bus.dmem_ack = 1'b0;
        check32("b2b lw out_valid", 32'(out_valid), 32'd1);
        check32("b2b lw out_data", out_data, 32'hCAFE_F00D);
        check32("b2b lw dmem_req dropped", 32'(bus.dmem_req), 32'd0);
        @(posedge clk); #1;

        // Reset while waiting for ack, then a late ack that must be ignored.
        in_valid = 1'b1; in_mem_op = MEM_OP_LW; in_alu_out = 32'h0000_5000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check32("rstwait dmem_req", 32'(bus.dmem_req), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check32("rstwait dmem_req after rst", 32'(bus.dmem_req), 32'd0);
        check32("rstwait in_ready after rst", 32'(in_ready), 32'd1);
        check32("rstwait out_valid after rst", 32'(out_valid), 32'd0);
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        bus.dmem_ack = 1'b0;
        check32("late ack out_valid", 32'(out_valid), 32'd0);
        check32("late ack dmem_req", 32'(bus.dmem_req), 32'd0);
        check32("late ack in_ready", 32'(in_ready), 32'd1);

        // Randomized ops, issued back-to-back, against the reference model.
        for (int k = 0; k < 300; k++) begin
            logic [3:0]  op;
            logic [31:0] alu;
            logic [31:0] rt;
            logic [31:0] rd;
            int          d;
            op  = 4'($urandom_range(0, 15));
            alu = $urandom;
            rt  = $urandom;
            rd  = $urandom;
            d   = $urandom_range(0, 3);
            e   = ref_model(op, alu, rt, rd, d);
            do_op(op, alu, rt, rd, d, r);
            compare($sformatf("rnd%0d op%0d", k, op), r, e, d);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
